// File: rtl/rr_stream_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   MAX_CH     - widest request vector the helpers handle (N_CH must be below it)
//   rr_pick_t  - grant vector plus found flag returned by rr_pick
//   next_idx   - wrap-around increment modulo n
//   rr_pick    - first requester at or above ptr, wrapping at n-1 to 0
package rr_stream_mux_pkg;

   localparam int MAX_CH = 32;
   localparam int MAX_W  = $clog2(MAX_CH);

   typedef struct packed {
      logic              found;
      logic [MAX_CH-1:0] grant;
   } rr_pick_t;

   // Increment that wraps at n-1 back to 0, so a non-power-of-2
   // channel count never produces an index outside 0..n-1.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   // Scan n positions starting at ptr. ptr is always below n, so
   // ptr+off is below 2n and a single subtraction performs the wrap.
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                        input int                ptr,
                                        input int                n);
      rr_pick_t r;
      int       idx;
      r.found = 1'b0;
      r.grant = '0;
      for (int off = 0; off < MAX_CH; off++) begin
         if (off < n) begin
            idx = ptr + off;
            if (idx >= n) begin
               idx = idx - n;
            end
            if (!r.found && req[idx[MAX_W-1:0]]) begin
               r.found                = 1'b1;
               r.grant[idx[MAX_W-1:0]] = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks the grant with its own load condition.
//
// Ports:
//   i_req   - request vector, bit i belongs to channel i
//   i_ptr   - channel that has highest priority this cycle (0..N_CH-1)
//   o_grant - one-hot grant, all zero when nothing requests
//   o_idx   - binary index of the granted channel (0 when none)
//   o_found - at least one request was granted
module rr_arbiter
   import rr_stream_mux_pkg::*;
#(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [N_CH-1:0]  o_grant,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_found
);

   logic [MAX_CH-1:0] w_req_ext;
   rr_pick_t          w_pick;

   always_comb begin
      w_req_ext           = '0;
      w_req_ext[N_CH-1:0] = i_req;
      w_pick              = rr_pick(w_req_ext, int'(i_ptr), N_CH);
   end

   assign o_grant = w_pick.grant[N_CH-1:0];

   // Upper grant bits can only be set if the scan escaped 0..N_CH-1;
   // refuse the grant outright rather than report a phantom channel.
   assign o_found = w_pick.found & ~(|w_pick.grant[MAX_CH-1:N_CH]);

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (o_grant[i]) begin
            o_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel to 1 valid/ready stream mux, round-robin or forced-select.
// Latency: 1 cycle from input transfer to o_out_valid; 1 word per cycle.
// Backpressure: all o_in_ready drop while the output word is held and not taken.
//
// Ports:
//   i_clk, i_rst         - clock, synchronous active-high reset
//   i_in_valid/i_in_data - per-channel requests, channel i at [i*WIDTH +: WIDTH]
//   o_in_ready           - per-channel accept (combinational)
//   i_force_en/sel       - fixed-select mode and the channel it selects
//   o_out_valid/data/src - registered output word and its source channel
//   i_out_ready          - consumer accept
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_CH-1:0]       i_in_valid,
   input  logic [N_CH*WIDTH-1:0] i_in_data,
   output logic [N_CH-1:0]       o_in_ready,
   input  logic                  i_force_en,
   input  logic [SEL_W-1:0]      i_force_sel,
   output logic                  o_out_valid,
   output logic [WIDTH-1:0]      o_out_data,
   output logic [SEL_W-1:0]      o_out_src,
   input  logic                  i_out_ready
);

   logic [SEL_W-1:0] r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_src;

   logic             w_load_ok;
   logic             w_found;
   logic             w_xfer;
   logic [N_CH-1:0]  w_req;
   logic [N_CH-1:0]  w_grant;
   logic [N_CH-1:0]  w_ready;
   logic [SEL_W-1:0] w_idx;
   logic [WIDTH-1:0] w_sel_data;

   // The output stage is free when empty or being drained this cycle.
   assign w_load_ok = !r_out_valid || i_out_ready;

   // In forced mode only the selected channel is eligible, whether or not
   // it is valid; an out-of-range select matches no bit and grants nothing.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_req[i] = i_force_en ? (int'(i_force_sel) == i) : i_in_valid[i];
      end
   end

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_found (w_found)
   );

   assign w_ready = w_grant & {N_CH{w_found && w_load_ok && !i_rst}};
   assign w_xfer  = |(i_in_valid & w_ready);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant[i]) begin
            w_sel_data = i_in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // A load takes priority over a plain drain, which gives the
   // consume-and-reload case with no bubble. The pointer moves only on a
   // real transfer, in both modes, so round-robin resumes after the last
   // winner.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_src   <= w_idx;
         r_ptr       <= SEL_W'(next_idx(int'(w_idx), N_CH));
      end else if (r_out_valid && i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_in_ready  = w_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_src   = r_out_src;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux: a 4-channel and a 3-channel instance
// driven side by side, directed scenarios then randomized traffic,
// checked against a per-cycle behavioural model of the mux.
module tb_rr_stream_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: N_CH=4
   logic        a_rst, a_fen, a_ovld, a_ordy;
   logic [3:0]  a_valid, a_ready, a_odat;
   logic [15:0] a_data;
   logic [1:0]  a_fsel, a_osrc;
   // instance B: N_CH=3
   logic        b_rst, b_fen, b_ovld, b_ordy;
   logic [2:0]  b_valid, b_ready;
   logic [11:0] b_data;
   logic [3:0]  b_odat;
   logic [1:0]  b_fsel, b_osrc;

   rr_stream_mux #(.WIDTH(4), .N_CH(4)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_in_valid(a_valid), .i_in_data(a_data),
      .o_in_ready(a_ready), .i_force_en(a_fen), .i_force_sel(a_fsel),
      .o_out_valid(a_ovld), .o_out_data(a_odat), .o_out_src(a_osrc),
      .i_out_ready(a_ordy));

   rr_stream_mux #(.WIDTH(4), .N_CH(3)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_in_valid(b_valid), .i_in_data(b_data),
      .o_in_ready(b_ready), .i_force_en(b_fen), .i_force_sel(b_fsel),
      .o_out_valid(b_ovld), .o_out_data(b_odat), .o_out_src(b_osrc),
      .i_out_ready(b_ordy));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model state per instance: d=0 is A, d=1 is B.
   int         m_ptr [2] = '{0, 0};
   logic       m_vld [2] = '{1'b0, 1'b0};
   logic [3:0] m_dat [2] = '{4'h0, 4'h0};
   int         m_src [2] = '{0, 0};

   function automatic int n_of(input int d);
      return (d == 0) ? 4 : 3;
   endfunction
   function automatic logic cur_rst(input int d);
      return (d == 0) ? a_rst : b_rst;
   endfunction
   function automatic logic cur_fen(input int d);
      return (d == 0) ? a_fen : b_fen;
   endfunction
   function automatic int cur_fsel(input int d);
      return (d == 0) ? int'(a_fsel) : int'(b_fsel);
   endfunction
   function automatic logic cur_ordy(input int d);
      return (d == 0) ? a_ordy : b_ordy;
   endfunction
   function automatic logic vbit(input int d, input int c);
      logic [3:0] v;
      v = (d == 0) ? a_valid : {1'b0, b_valid};
      return v[c];
   endfunction
   function automatic logic [3:0] cur_data(input int d, input int c);
      if (d == 0) return a_data[c*4 +: 4];
      return b_data[c*4 +: 4];
   endfunction

   // Which channel the spec rules grant this cycle, -1 for none.
   function automatic int m_grant(input int d);
      int n, c;
      n = n_of(d);
      if (cur_rst(d)) return -1;
      if (m_vld[d] && !cur_ordy(d)) return -1;
      if (cur_fen(d)) return (cur_fsel(d) < n) ? cur_fsel(d) : -1;
      for (int k = 0; k < n; k++) begin
         c = (m_ptr[d] + k) % n;
         if (vbit(d, c)) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(input int d);
      logic [3:0] r;
      int g;
      r = 4'b0000;
      g = m_grant(d);
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // One clock: evaluate transfers from pre-edge inputs, advance model,
   // return at the falling edge where new inputs are driven.
   task automatic cycle();
      int         g  [2];
      logic       x  [2];
      logic [3:0] dt [2];
      for (int d = 0; d < 2; d++) begin
         g[d]  = m_grant(d);
         x[d]  = (g[d] >= 0) && vbit(d, g[d]);
         dt[d] = x[d] ? cur_data(d, g[d]) : 4'h0;
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (cur_rst(d)) begin
            m_vld[d] = 1'b0; m_dat[d] = 4'h0; m_src[d] = 0; m_ptr[d] = 0;
         end else if (x[d]) begin
            m_vld[d] = 1'b1; m_dat[d] = dt[d]; m_src[d] = g[d];
            m_ptr[d] = (g[d] + 1) % n_of(d);
         end else if (m_vld[d] && cur_ordy(d)) begin
            m_vld[d] = 1'b0;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1; a_fen = 1'b0; b_fen = 1'b0;
      a_fsel = 2'd0; b_fsel = 2'd0; a_ordy = 1'b1; b_ordy = 1'b1;
      a_valid = 4'hF; b_valid = 3'h7;
      a_data = 16'h3210; b_data = 12'h210;
      for (int k = 0; k < 2; k++) begin
         cycle();
         #1;
         checks++; if (a_ready !== 4'b0000) begin failures++;
            $display("FAIL reset_ready cyc=%0d got=%b exp=0000", cyc, a_ready); end
         checks++; if (a_ovld !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", cyc, a_ovld); end
         checks++; if (a_odat !== 4'h0 || a_osrc !== 2'd0) begin failures++;
            $display("FAIL reset_out_data cyc=%0d got=%h/%0d exp=0/0", cyc, a_odat, a_osrc); end
         checks++; if (b_ready !== 3'b000 || b_ovld !== 1'b0) begin failures++;
            $display("FAIL reset_b cyc=%0d got=%b/%b exp=000/0", cyc, b_ready, b_ovld); end
      end
      @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0;
      #1;
      checks++; if (a_ready !== 4'b0001) begin failures++;
         $display("FAIL reset_first_grant_a got=%b exp=0001", a_ready); end
      checks++; if (b_ready !== 3'b001) begin failures++;
         $display("FAIL reset_first_grant_b got=%b exp=001", b_ready); end
   endtask

   task automatic test_round_robin();
      b_valid = 3'b000;
      a_valid = 4'hF; a_data = 16'h3210; a_ordy = 1'b1;
      for (int k = 0; k < 9; k++) begin
         #1;
         checks++; if (a_ready !== 4'(1 << (k % 4))) begin failures++;
            $display("FAIL rr_ready k=%0d got=%b exp=%b", k, a_ready, 4'(1 << (k % 4))); end
         if (k == 0) begin
            checks++; if (a_ovld !== 1'b0) begin failures++;
               $display("FAIL rr_latency got=%b exp=0", a_ovld); end
         end else begin
            checks++; if (a_ovld !== 1'b1 || int'(a_osrc) != (k-1) % 4 || int'(a_odat) != (k-1) % 4) begin
               failures++;
               $display("FAIL rr_out k=%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, a_ovld, a_osrc, a_odat,
                        (k-1) % 4, (k-1) % 4); end
         end
         cycle();
      end
   endtask

   task automatic test_sparse_wrap();
      // one transfer on ch1 leaves the pointer at 2
      a_valid = 4'b0010;
      #1;
      checks++; if (a_ready !== 4'b0010) begin failures++;
         $display("FAIL sparse_setup got=%b exp=0010", a_ready); end
      cycle();
      a_valid = 4'b1010;
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++; if (a_ready !== ((j % 2 == 0) ? 4'b1000 : 4'b0010)) begin failures++;
            $display("FAIL sparse_grant j=%0d got=%b exp=%b", j, a_ready,
                     (j % 2 == 0) ? 4'b1000 : 4'b0010); end
         cycle();
      end
      #1;
      checks++; if (a_osrc !== 2'd1) begin failures++;
         $display("FAIL sparse_last_src got=%0d exp=1", a_osrc); end
      a_valid = 4'b0000;
      b_valid = 3'b111; b_data = 12'h210; b_ordy = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++; if (b_ready !== 3'(1 << (j % 3))) begin failures++;
            $display("FAIL wrap3_grant j=%0d got=%b exp=%b", j, b_ready, 3'(1 << (j % 3))); end
         if (j > 0) begin
            checks++; if (int'(b_osrc) != (j-1) % 3 || int'(b_odat) != (j-1) % 3) begin failures++;
               $display("FAIL wrap3_src j=%0d got=%0d exp=%0d", j, b_osrc, (j-1) % 3); end
         end
         cycle();
      end
      #1;
      checks++; if (b_osrc !== 2'd0) begin failures++;
         $display("FAIL wrap3_wrap got=%0d exp=0", b_osrc); end
      b_valid = 3'b000;
   endtask

   task automatic test_backpressure();
      a_valid = 4'b0001; a_data = 16'h000A; a_ordy = 1'b1;
      cycle();
      a_ordy = 1'b0; a_valid = 4'hF; a_data = 16'hFFFF;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++; if (a_ovld !== 1'b1 || a_odat !== 4'hA || a_ready !== 4'b0000) begin failures++;
            $display("FAIL stall j=%0d got=%b/%h/%b exp=1/a/0000", j, a_ovld, a_odat, a_ready); end
         cycle();
      end
      a_ordy = 1'b1; a_valid = 4'b0100; a_data = 16'h0500;
      #1;
      checks++; if (a_ready !== 4'b0100 || a_ovld !== 1'b1) begin failures++;
         $display("FAIL bp_release got=%b/%b exp=0100/1", a_ready, a_ovld); end
      cycle();
      #1;
      checks++; if (a_ovld !== 1'b1 || a_odat !== 4'h5 || a_osrc !== 2'd2) begin failures++;
         $display("FAIL bp_no_bubble got=%b/%h/%0d exp=1/5/2", a_ovld, a_odat, a_osrc); end
      a_valid = 4'b0000;
      cycle();
      #1;
      checks++; if (a_ovld !== 1'b0 || a_odat !== 4'h5 || a_osrc !== 2'd2) begin failures++;
         $display("FAIL bp_drain_keeps got=%b/%h/%0d exp=0/5/2", a_ovld, a_odat, a_osrc); end
   endtask

   task automatic test_forced();
      a_fen = 1'b1; a_fsel = 2'd2; a_valid = 4'hF; a_data = 16'h3210; a_ordy = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++; if (a_ready !== 4'b0100) begin failures++;
            $display("FAIL force_grant j=%0d got=%b exp=0100", j, a_ready); end
         if (j > 0) begin
            checks++; if (a_osrc !== 2'd2 || a_odat !== 4'h2) begin failures++;
               $display("FAIL force_out j=%0d got=%0d/%h exp=2/2", j, a_osrc, a_odat); end
         end
         cycle();
      end
      a_fen = 1'b0;
      #1;
      checks++; if (a_ready !== 4'b1000) begin failures++;
         $display("FAIL force_resume got=%b exp=1000", a_ready); end
      cycle();
      a_valid = 4'b0000;
      b_fen = 1'b1; b_fsel = 2'd3; b_valid = 3'b111; b_ordy = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++; if (b_ready !== 3'b000 || b_ovld !== 1'b0) begin failures++;
            $display("FAIL force_oob j=%0d got=%b/%b exp=000/0", j, b_ready, b_ovld); end
         cycle();
      end
      b_fen = 1'b0;
      #1;
      // pointer untouched by the out-of-range phase: still 1 from the wrap test
      checks++; if (b_ready !== 3'b010) begin failures++;
         $display("FAIL force_oob_ptr got=%b exp=010", b_ready); end
      b_valid = 3'b000;
   endtask

   task automatic test_reset_midstream();
      a_valid = 4'b0001; a_data = 16'h3337; a_ordy = 1'b1;
      cycle();
      a_ordy = 1'b0; a_valid = 4'b0000;
      #1;
      checks++; if (a_ovld !== 1'b1 || a_odat !== 4'h7) begin failures++;
         $display("FAIL mid_hold got=%b/%h exp=1/7", a_ovld, a_odat); end
      cycle();
      a_rst = 1'b1;
      cycle();
      a_rst = 1'b0; a_valid = 4'hF; a_data = 16'h3333; a_ordy = 1'b1;
      #1;
      checks++; if (a_ovld !== 1'b0) begin failures++;
         $display("FAIL mid_discard got=%b exp=0", a_ovld); end
      checks++; if (a_ready !== 4'b0001) begin failures++;
         $display("FAIL mid_ptr got=%b exp=0001", a_ready); end
      cycle();
      #1;
      checks++; if (a_odat !== 4'h3 || a_osrc !== 2'd0) begin failures++;
         $display("FAIL mid_next got=%h/%0d exp=3/0", a_odat, a_osrc); end
   endtask

   task automatic test_random();
      logic [3:0] e;
      for (int t = 0; t < 600; t++) begin
         a_valid = 4'($urandom); a_data = 16'($urandom);
         a_ordy  = ($urandom_range(0, 3) != 0); a_fen = ($urandom_range(0, 6) == 0);
         a_fsel  = 2'($urandom); a_rst = ($urandom_range(0, 49) == 0);
         b_valid = 3'($urandom); b_data = 12'($urandom);
         b_ordy  = ($urandom_range(0, 3) != 0); b_fen = ($urandom_range(0, 6) == 0);
         b_fsel  = 2'($urandom); b_rst = ($urandom_range(0, 49) == 0);
         #1;
         e = m_ready(0);
         checks++; if (a_ready !== e) begin failures++;
            $display("FAIL rand_a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, e); end
         checks++; if (a_ovld !== m_vld[0] || a_odat !== m_dat[0] || int'(a_osrc) != m_src[0]) begin
            failures++;
            $display("FAIL rand_a_out cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", cyc, a_ovld, a_odat,
                     a_osrc, m_vld[0], m_dat[0], m_src[0]); end
         e = m_ready(1);
         checks++; if ({1'b0, b_ready} !== e) begin failures++;
            $display("FAIL rand_b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, e[2:0]); end
         checks++; if (b_ovld !== m_vld[1] || b_odat !== m_dat[1] || int'(b_osrc) != m_src[1]) begin
            failures++;
            $display("FAIL rand_b_out cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", cyc, b_ovld, b_odat,
                     b_osrc, m_vld[1], m_dat[1], m_src[1]); end
         cycle();
      end
      a_rst = 1'b0; b_rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse_wrap();
      test_backpressure();
      test_forced();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
